// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults for the show-ahead FIFO controller
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam int FIFO_AFULL_TH   = 12;
    localparam int FIFO_AEMPTY_TH  = 2;

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/flag controller turning a sync-write/async-read RAM into a show-ahead FIFO
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AFULL_TH   = FIFO_AFULL_TH,
    parameter int AEMPTY_TH  = FIFO_AEMPTY_TH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr_err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AFULL_V  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_V = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                push_ok;
    logic                pop_ok;

    // A push while full is still taken when a pop frees the head slot in the same cycle.
    always_comb begin
        push_ok = push & (~full | pop);
        pop_ok  = pop & ~empty;
        we      = push_ok;
    end

    assign waddr = wptr[ADDR_WIDTH-1:0];
    assign raddr = rptr[ADDR_WIDTH-1:0];

    always_comb begin
        full         = (count == DEPTH_V);
        empty        = (count == '0);
        almost_full  = (count >= AFULL_V);
        almost_empty = (count <= AEMPTY_V);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Sticky errors: a new event in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push & ~push_ok) | (overflow & ~clr_err);
            underflow <= (pop & ~pop_ok) | (underflow & ~clr_err);
        end
    end

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!reset_n)
        count == (wptr - rptr));
    a_count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        count <= DEPTH_V);

endmodule
